// File: rtl/dz_pkg.sv
// Shared constants for the DZ11 modem-control slice.
package dz_pkg;
    localparam int unsigned DZLINES = 8;
    localparam int unsigned DZFILTW = 8;
endpackage

// File: rtl/dz_modem_line.sv
// One line's conditioning: tick-based CO debounce and RI pulse stretch.
module dz_modem_line
    import dz_pkg::*;
#(
    parameter int unsigned COSTABLE = 8,
    parameter int unsigned RIHOLD   = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic sync_co,
    input  logic sync_ri,
    output logic co,
    output logic ri,
    output logic co_change
);

    localparam logic [DZFILTW-1:0] CoLast = DZFILTW'(COSTABLE - 1);
    localparam logic [DZFILTW-1:0] RiLoad = DZFILTW'(RIHOLD);

    logic [DZFILTW-1:0] co_cnt;
    logic [DZFILTW-1:0] ri_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            co        <= 1'b0;
            co_change <= 1'b0;
            co_cnt    <= '0;
            ri        <= 1'b0;
            ri_cnt    <= '0;
        end else begin
            co_change <= 1'b0;
            // Any agreeing tick restarts the count, so only a sustained level gets through.
            if (tick) begin
                if (sync_co == co) begin
                    co_cnt <= '0;
                end else if (co_cnt == CoLast) begin
                    co        <= ~co;
                    co_change <= 1'b1;
                    co_cnt    <= '0;
                end else begin
                    co_cnt <= co_cnt + 1'b1;
                end
            end
            // Reload wins over a same-cycle tick decrement.
            if (sync_ri) begin
                ri     <= 1'b1;
                ri_cnt <= RiLoad;
            end else if (tick) begin
                if (ri_cnt > 1) begin
                    ri_cnt <= ri_cnt - 1'b1;
                end else if (ri_cnt == 1) begin
                    ri_cnt <= '0;
                    ri     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/dz_modem_filter.sv
// DZ11 carrier-detect debounce and ring-indicator stretch ahead of the MSR synchronizer.
module dz_modem_filter
    import dz_pkg::*;
#(
    parameter int unsigned TICKDIV  = 20000,
    parameter int unsigned COSTABLE = 8,
    parameter int unsigned RIHOLD   = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DZLINES-1:0] rawCO,
    input  logic [DZLINES-1:0] rawRI,
    output logic [DZLINES-1:0] dz11CO,
    output logic [DZLINES-1:0] dz11RI,
    output logic [DZLINES-1:0] coChange
);

    localparam int unsigned   PreW    = $clog2(TICKDIV);
    localparam logic [PreW-1:0] PreLast = PreW'(TICKDIV - 1);

    logic [DZLINES-1:0] co_meta, co_sync;
    logic [DZLINES-1:0] ri_meta, ri_sync;
    logic [PreW-1:0]    pre_cnt;
    logic               tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            co_meta <= '0;
            co_sync <= '0;
            ri_meta <= '0;
            ri_sync <= '0;
        end else begin
            co_meta <= rawCO;
            co_sync <= co_meta;
            ri_meta <= rawRI;
            ri_sync <= ri_meta;
        end
    end

    assign tick = (pre_cnt == PreLast);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < DZLINES; i++) begin : g_line
        dz_modem_line #(
            .COSTABLE(COSTABLE),
            .RIHOLD  (RIHOLD)
        ) u_line (
            .clk      (clk),
            .rst      (rst),
            .tick     (tick),
            .sync_co  (co_sync[i]),
            .sync_ri  (ri_sync[i]),
            .co       (dz11CO[i]),
            .ri       (dz11RI[i]),
            .co_change(coChange[i])
        );
    end

endmodule

// File: tb/tb_dz_modem_filter.sv
// Scoreboard bench: stimulus queues expected output changes, a monitor checks each change.
module tb_dz_modem_filter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rawCO = 8'h00;
    logic [7:0] rawRI = 8'h00;
    logic [7:0] dz11CO, dz11RI, coChange;

    typedef struct {
        int          cyc;
        logic [23:0] val;
    } ev_t;

    ev_t         exp_q[$];
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    int          r = 0;
    logic [23:0] prev = 24'h0;

    dz_modem_filter #(
        .TICKDIV (4),
        .COSTABLE(3),
        .RIHOLD  (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rawCO   (rawCO),
        .rawRI   (rawRI),
        .dz11CO  (dz11CO),
        .dz11RI  (dz11RI),
        .coChange(coChange)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic [7:0] co, input logic [7:0] ri,
                        input logic [7:0] chg);
        ev_t e;
        e.cyc = c;
        e.val = {co, ri, chg};
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h want %h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    // Reset with raw inputs as they are; outputs must clear without waiting for a clock.
    task automatic do_reset(input bit drop);
        if (drop) push(cyc, 8'h00, 8'h00, 8'h00);
        rst = 1'b0;
        #1;
        check("rst_immediate", {dz11CO, dz11RI, coChange}, 24'h0);
        step(2);
        rst = 1'b1;
        r   = cyc;
    endtask

    always @(negedge clk) begin
        logic [23:0] cur;
        ev_t         e;
        cur = {dz11CO, dz11RI, coChange};
        if (cur !== prev) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_change: got %h at cyc %0d, none expected", cur, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.val !== cur) begin
                    fails++;
                    $display("FAIL out_change: got %h at cyc %0d want %h at cyc %0d",
                             cur, cyc, e.val, e.cyc);
                end
            end
        end
        prev = cur;
    end

    initial begin
        // 1: reset with all raw inputs high, then release
        rawCO = 8'hFF;
        rawRI = 8'hFF;
        #1 rst = 1'b0;
        #1 check("rst_async", {dz11CO, dz11RI, coChange}, 24'h0);
        step(3);
        check("rst_hold", {dz11CO, dz11RI, coChange}, 24'h0);
        rst = 1'b1;
        r   = cyc;
        push(r + 3,  8'h00, 8'hFF, 8'h00);
        push(r + 12, 8'hFF, 8'hFF, 8'hFF);
        push(r + 13, 8'hFF, 8'hFF, 8'h00);
        step(16);
        check("s1_steady", {dz11CO, dz11RI, coChange}, {8'hFF, 8'hFF, 8'h00});
        rawCO = 8'h00;
        rawRI = 8'h00;
        do_reset(1'b1);

        // 2: 5-clk CO glitch spans two ticks but never three
        step(1);
        rawCO = 8'h04;
        step(5);
        rawCO = 8'h00;
        step(20);
        check("s2_no_glitch", {dz11CO, dz11RI, coChange}, 24'h0);
        do_reset(1'b0);

        // 3: CO debounce rise then fall on line 5
        step(1);
        rawCO = 8'h20;
        push(r + 12, 8'h20, 8'h00, 8'h20);
        push(r + 13, 8'h20, 8'h00, 8'h00);
        step(13);
        rawCO = 8'h00;
        push(r + 28, 8'h00, 8'h00, 8'h20);
        push(r + 29, 8'h00, 8'h00, 8'h00);
        step(20);
        check("s3_settled", {dz11CO, dz11RI, coChange}, 24'h0);
        do_reset(1'b0);

        // 4: single-clk RI pulse on line 0, away from a tick
        step(2);
        rawRI = 8'h01;
        step(1);
        rawRI = 8'h00;
        push(r + 5,  8'h00, 8'h01, 8'h00);
        push(r + 12, 8'h00, 8'h00, 8'h00);
        step(16);
        do_reset(1'b0);

        // 5: RI pulse on line 7 landing in a tick clk: reload, no decrement
        step(1);
        rawRI = 8'h80;
        step(1);
        rawRI = 8'h00;
        push(r + 4,  8'h00, 8'h80, 8'h00);
        push(r + 12, 8'h00, 8'h00, 8'h00);
        step(16);
        do_reset(1'b0);

        // 6: reset mid-debounce and mid-hold; debounce restarts from zero
        step(1);
        rawCO = 8'h01;
        step(1);
        rawRI = 8'h08;
        step(1);
        rawRI = 8'h00;
        push(r + 5, 8'h00, 8'h08, 8'h00);
        step(6);
        check("s6_pre_reset", {dz11CO, dz11RI, coChange}, {8'h00, 8'h08, 8'h00});
        do_reset(1'b1);
        push(r + 12, 8'h01, 8'h00, 8'h01);
        push(r + 13, 8'h01, 8'h00, 8'h00);
        step(20);
        check("s6_final", {dz11CO, dz11RI, coChange}, {8'h01, 8'h00, 8'h00});

        while (exp_q.size() != 0) begin
            ev_t e;
            e = exp_q.pop_front();
            tests++;
            fails++;
            $display("FAIL missing_change: want %h at cyc %0d, never seen", e.val, e.cyc);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dz_modem_filter.md
# dz_modem_filter

Conditions the raw per-line Carrier Detect (CO) and Ring Indicator (RI) inputs of the DZ11 before they reach the Modem Status Register synchronizer. The block sits directly upstream of the MSR stage and drives its `dz11CO`/`dz11RI` inputs.
- CO: metastability synchronizer, then a tick-based debounce filter.
- RI: synchronizer, then a pulse stretcher, so intermittent ring cadence reads as a steady ring.

## Interface
Parameters:
- `TICKDIV`, 20000: clk cycles per filter tick (1 ms at 20 MHz); ≥2.
- `COSTABLE`, 8: consecutive disagreeing ticks needed to change a CO output; 1–255.
- `RIHOLD`, 255: ticks RI output is held after the last RI activity; 1–255.

Ports:
- `clk`  in  1  Clock.
- `rst`  in  1  Reset; asynchronous assertion, **active-low**.
- `rawCO`  in  8  Raw carrier detect, one bit per line, asynchronous to clk.
- `rawRI`  in  8  Raw ring indicator, one bit per line, asynchronous to clk.
- `dz11CO`  out  8  Filtered carrier detect, registered.
- `dz11RI`  out  8  Stretched ring indicator, registered.
- `coChange`  out  8  One-clk pulse per line when that `dz11CO` bit changes, registered.

## Operation
Synchronizer:
- Two flops per bit on `rawCO` and `rawRI` produce `syncCO` and `syncRI`.
- Reset value 0.

Tick prescaler:
- Shared counter counts 0..TICKDIV-1 and wraps.
- `tick` is high for the one clk in which the counter equals TICKDIV-1.

CO debounce, per line i:
- 8-bit counter `coCnt[i]`; evaluated only on `tick`.
- If `syncCO[i]` equals `dz11CO[i]`: `coCnt[i]` ← 0.
- Else, if `coCnt[i]` equals COSTABLE-1: toggle `dz11CO[i]`, pulse `coChange[i]`, and set `coCnt[i]` ← 0.
- Else: increment `coCnt[i]`.
- A single agreeing tick restarts the count, so glitches shorter than one tick period never propagate.

RI stretch, per line i:
- 8-bit counter `riCnt[i]`.
- Any clk with `syncRI[i]` = 1: `dz11RI[i]` ← 1 and `riCnt[i]` ← RIHOLD, regardless of `tick`.
- Else, on `tick` with `riCnt[i]` > 1: decrement.
- Else, on `tick` with `riCnt[i]` = 1: `riCnt[i]` ← 0 and `dz11RI[i]` ← 0.
- When `riCnt[i]` = 0 the counter holds.
- `syncRI` high in the same clk as `tick` is a reload; reload has priority over decrement.

Lines are fully independent. Only the prescaler is shared.

## Timing
- Reset (`rst` = 0): all outputs, synchronizer flops, the prescaler and every counter go to 0 immediately. No pulses are emitted during reset or on release.
- The prescaler restarts from 0 on reset release, so the first `tick` occurs TICKDIV clks after release.
- RI assert latency: 3 clk from the `rawRI` edge to `dz11RI` (2 sync + 1 output register).
- RI deassert: between RIHOLD-1 and RIHOLD tick periods after `syncRI` falls, on a `tick` edge.
- CO change: `dz11CO` toggles on the COSTABLE-th consecutive disagreeing `tick`.
  - Latency from `syncCO` change is between (COSTABLE-1)·TICKDIV+1 and COSTABLE·TICKDIV clk.
  - `coChange` is high in the same clk that `dz11CO` first shows the new value.
- Reset mid-count discards all partial debounce and hold state.
- The output encoding `{dz11CO, dz11RI}` matches the MSR register layout: CO in bits 15:8, RI in bits 7:0.

## Structure
- Shared package `dz_pkg`: line count constant `DZLINES` = 8, counter width `DZFILTW` = 8.
- One natural sub-module, `dz_modem_line`, holds one line's CO debounce and RI stretch. The top instantiates it 8 times with a generate loop and owns the synchronizers and the prescaler.
- Expected size: about 150–250 lines total.

## Test plan
All scenarios use TICKDIV=4, COSTABLE=3, RIHOLD=2.

1. Reset: assert `rst`=0 with all raw inputs high -> all outputs read 0x00. After release, `dz11RI` = 0xFF at clk 3 and `dz11CO` = 0xFF after 3 ticks, with one `coChange` = 0xFF pulse.
2. CO glitch: `rawCO[2]` high for 5 clk, then low -> `dz11CO` stays 0x00 and `coChange` never pulses.
3. CO debounce: `rawCO[5]` held high -> `dz11CO` = 0x20 on the 3rd tick after `syncCO[5]` rises. `coChange` = 0x20 for exactly 1 clk. Dropping `rawCO[5]` produces a matching falling transition.
4. RI stretch: one-clk `rawRI[0]` pulse -> `dz11RI[0]` = 1 three clk later, then 0 on the 2nd tick after `syncRI[0]` falls.
5. RI reload on tick: `rawRI[7]` pulse timed so `syncRI[7]` is high in a `tick` clk -> `riCnt[7]` = 2 and no decrement occurs.
6. Mid-operation reset: assert `rst` while a debounce or RI hold is in progress -> outputs 0 immediately. After release, full debounce restarts from 0.
